timer_peripheral: RTL
=====================

# timer_peripheral

Memory-mapped peripheral block that answers the pipeline CPU's data-memory load/store accesses in the peripheral address window. It holds a reloadable 32-bit timer with an interrupt request, an LED register, a seven-segment digit register and an optional free-running system tick counter. It sits beside the data memory on the MEM stage. The top level routes accesses whose address matches `BASE_ADDR[31:8]` here and ORs `ReadData` with the memory read data.

## Interface
- `BASE_ADDR`, default 32'h40000000: base of the 256-byte peripheral window; bits [7:0] must be zero.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `MemRead` input 1: MEM-stage load strobe.
- `MemWrite` input 1: MEM-stage store strobe.
- `Address` input 32: byte address of the access (ALU result from EX/MEM).
- `WriteData` input 32: store data.
- `ReadData` output 32: load data; combinational.
- `IRQ` output 1: timer interrupt request, level.
- `leds` output 8: LED register.
- `digi` output 12: seven-segment register (bits [11:8] anode select, bits [7:0] segments).

## Operation
- Hit when `Address[31:8] == BASE_ADDR[31:8]`. Register select is `Address[7:2]`. `Address[1:0]` is ignored; every access is a full word.
- Register map (offset: name, access):
  - 0x00: TH, RW. Reload value.
  - 0x04: TL, RW. Counter.
  - 0x08: TCON[2:0], RW. Bit 0 = enable, bit 1 = irq enable, bit 2 = irq status. Bits [31:3] read as 0.
  - 0x0C: leds[7:0], RW.
  - 0x10: digi[11:0], RW.
  - 0x14: SYSTICK, RO.
- Unmapped offsets, or any non-hit address: reads return 0 and writes are ignored.
- `ReadData` = selected register when `MemRead & hit`, otherwise 32'h0.
- Timer, each cycle with TCON[0]=1:
  - If TL == 32'hFFFFFFFF: TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
  - Otherwise TL <= TL + 1.
- With TCON[0]=0, TL holds its value.
- `IRQ` = TCON[1] & TCON[2]. Software clears the interrupt by writing TCON with bit 2 = 0.
- Writing TCON bit 2 = 1 sets the status directly (software interrupt).
- Simultaneous events:
  - A CPU write to TL in the same cycle as a timer increment or reload: the write wins.
  - A CPU write to TCON in the same cycle as an overflow that would set status: the written value wins.
  - `MemRead` and `MemWrite` both high: the write occurs at the edge, and the read returns the pre-write value.
- Writes to SYSTICK are ignored.
- SYSTICK increments every cycle and wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset (`reset`=0, asynchronous): TH=0, TL=0, TCON=0, leds=0, digi=0, SYSTICK=0, `IRQ`=0.
  - `ReadData` is 0 during reset unless a read hits; a read then returns the reset values.
  - Reset asserted mid-count aborts counting immediately. Counting does not resume after release until TCON[0] is written.
- Read latency is 0 cycles: `ReadData` is combinational from the current registers, matching the data memory.
- Write latency is 1 edge: the new value is visible on `ReadData` and outputs in the cycle after the store.
- Timer with TCON[0]=1 and TL=32'hFFFFFFFE at edge n:
  - TL=32'hFFFFFFFF after edge n.
  - TL=TH after edge n+1.
  - TCON[2] and `IRQ` rise after edge n+1.
- `IRQ` is registered-state derived and has no combinational path from the bus inputs.

## Configuration
- `SYSTICK_EN` defined: the 32-bit SYSTICK counter is built and readable at offset 0x14.
- `SYSTICK_EN` undefined: no counter is instantiated, and offset 0x14 behaves as unmapped (reads 0).

## Test plan
- Reset value check: assert `reset`=0 mid-run, then read each offset 0x00–0x14 -> all return 0, and `IRQ`=0, `leds`=0, `digi`=0.
- Register writeback:
  - Write 0x000000A5 to 0x4000000C -> `leds`=8'hA5 next cycle.
  - Write 0x00000F3C to 0x40000010 -> `digi`=12'hF3C.
  - Write 0x12345678 to 0x40000020 -> ignored; a read of 0x40000020 returns 0.
- Reload and interrupt:
  - TH=32'hFFFFFFF0, TL=32'hFFFFFFFD, TCON=3 -> TL reads 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFF0 on successive cycles.
  - `IRQ` goes high with the reload.
  - Writing TCON=3 clears `IRQ` next cycle.
- Irq disabled: TCON=1 through an overflow -> TL reloads, TCON reads 1, `IRQ` stays 0.
- Write-vs-count collision: timer enabled, write TL=0x00000100 -> TL reads 0x00000100 next cycle, then 0x00000101.
- SYSTICK:
  - With `SYSTICK_EN`: two reads 5 cycles apart differ by 5, and a write to 0x14 has no effect.
  - Without `SYSTICK_EN`: reads return 0.

Source files
------------

// File: rtl/timer_peripheral.sv
// Memory-mapped timer / LED / seven-segment peripheral on the MEM-stage data bus.
// Define SYSTICK_EN to build the free-running SYSTICK counter at offset 0x14.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ,
    output logic [7:0]  leds,
    output logic [11:0] digi
);

    localparam logic [5:0] REG_TH      = 6'd0;
    localparam logic [5:0] REG_TL      = 6'd1;
    localparam logic [5:0] REG_TCON    = 6'd2;
    localparam logic [5:0] REG_LEDS    = 6'd3;
    localparam logic [5:0] REG_DIGI    = 6'd4;
`ifdef SYSTICK_EN
    localparam logic [5:0] REG_SYSTICK = 6'd5;
`endif

    logic        hit;
    logic [5:0]  sel;
    logic        wr_en;
    logic        unused_addr_lsbs;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  leds_q, leds_d;
    logic [11:0] digi_q, digi_d;

    assign hit              = (Address[31:8] == BASE_ADDR[31:8]);
    assign sel              = Address[7:2];
    assign wr_en            = MemWrite & hit;
    assign unused_addr_lsbs = ^Address[1:0];

    // Timer advance is computed first so a same-cycle CPU write overrides it.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        leds_d = leds_q;
        digi_d = digi_q;
        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr_en) begin
            case (sel)
                REG_TH:   th_d   = WriteData;
                REG_TL:   tl_d   = WriteData;
                REG_TCON: tcon_d = WriteData[2:0];
                REG_LEDS: leds_d = WriteData[7:0];
                REG_DIGI: digi_d = WriteData[11:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            leds_q <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            leds_q <= leds_d;
            digi_q <= digi_d;
        end
    end

`ifdef SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_q + 32'd1;
        end
    end
`endif

    // Read port is combinational so a simultaneous store still returns the old value.
    always_comb begin
        ReadData = '0;
        if (MemRead && hit) begin
            case (sel)
                REG_TH:      ReadData = th_q;
                REG_TL:      ReadData = tl_q;
                REG_TCON:    ReadData = {29'd0, tcon_q};
                REG_LEDS:    ReadData = {24'd0, leds_q};
                REG_DIGI:    ReadData = {20'd0, digi_q};
`ifdef SYSTICK_EN
                REG_SYSTICK: ReadData = systick_q;
`endif
                default:     ReadData = '0;
            endcase
        end
    end

    assign IRQ  = tcon_q[1] & tcon_q[2];
    assign leds = leds_q;
    assign digi = digi_q;

endmodule
